// File: rtl/hamming74_pkg.sv
// Hamming(7,4) shared definitions: code layout, encode/syndrome helpers and
// the transmit shift-register command set used by the serial encoder.
package hamming74_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  // Data bits sit at 0,1,2,4; parity bits at 3,5,6.
  localparam logic [2:0] D0_POS = 3'd0;
  localparam logic [2:0] D1_POS = 3'd1;
  localparam logic [2:0] D2_POS = 3'd2;
  localparam logic [2:0] D3_POS = 3'd4;
  localparam logic [2:0] P0_POS = 3'd3;
  localparam logic [2:0] P1_POS = 3'd5;
  localparam logic [2:0] P2_POS = 3'd6;

  typedef enum logic [1:0] {TX_CLR, TX_LOAD, TX_SHIFT, TX_GAP} tx_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              inj;
    logic [2:0]        pos;
  } tx_req_t;

  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P0_POS] = d[2] ^ d[1] ^ d[0];
    c[P1_POS] = d[3] ^ d[1] ^ d[0];
    c[P2_POS] = d[3] ^ d[2] ^ d[0];
    return c;
  endfunction

  // Zero for every valid codeword.
  function automatic logic [2:0] hamming74_syndrome(input logic [CODE_W-1:0] c);
    return {c[P0_POS] ^ c[D2_POS] ^ c[D1_POS] ^ c[D0_POS],
            c[P1_POS] ^ c[D3_POS] ^ c[D1_POS] ^ c[D0_POS],
            c[P2_POS] ^ c[D3_POS] ^ c[D2_POS] ^ c[D0_POS]};
  endfunction

  // Position 7 is the "no flip" code.
  function automatic logic [CODE_W-1:0] flip_mask(input logic inj, input logic [2:0] pos);
    return (inj && pos != 3'd7) ? (CODE_W'(1) << pos) : '0;
  endfunction

endpackage

// File: rtl/hamming74_shift_tx.sv
// 7-bit load/shift register with bit counter; bit_out is the registered serial line.
module hamming74_shift_tx import hamming74_pkg::*; #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  tx_cmd_t           cmd,
  input  logic [CODE_W-1:0] word,
  output logic              bit_out,
  output logic [2:0]        cnt
);

  logic [CODE_W-1:0] sreg;

  // Load puts c0 straight on the line and keeps the rest queued, LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      cnt     <= '0;
      bit_out <= IDLE_LEVEL;
    end else if (ena) begin
      unique case (cmd)
        TX_LOAD: begin
          sreg    <= {1'b0, word[CODE_W-1:1]};
          bit_out <= word[0];
          cnt     <= '0;
        end
        TX_SHIFT: begin
          sreg    <= {1'b0, sreg[CODE_W-1:1]};
          bit_out <= sreg[0];
          cnt     <= cnt + 3'd1;
        end
        TX_GAP: begin
          sreg    <= '0;
          bit_out <= IDLE_LEVEL;
          cnt     <= cnt + 3'd1;
        end
        default: begin
          sreg    <= '0;
          bit_out <= IDLE_LEVEL;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Hamming(7,4) serial transmitter: valid/ready nibble intake, 7 code bits LSB
// first, then GAP_CYCLES idle bits; optional single-bit error injection.
module hamming74_serial_encoder import hamming74_pkg::*; #(
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              err_inject,
  input  logic [2:0]        err_pos,
  output logic              encode_out,
  output logic              frame_start,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [2:0] SEND_LAST = 3'(CODE_W - 1);
  localparam logic [2:0] GAP_LAST  = 3'(GAP_CYCLES - 1);

  state_t            state;
  tx_req_t           req;
  tx_cmd_t           cmd;
  logic [CODE_W-1:0] word;
  logic [2:0]        cnt;
  logic              gap_last, ready_st, accept;

  assign req        = '{data: data_in, inj: err_inject, pos: err_pos};
  assign word       = hamming74_encode(req.data) ^ flip_mask(req.inj, req.pos);
  assign gap_last   = (state == GAP) && (cnt == GAP_LAST);
  assign ready_st   = (state == IDLE) || gap_last;
  assign data_ready = ena && !rst && ready_st;
  assign accept     = data_valid && data_ready;

  always_comb begin
    cmd = TX_CLR;
    unique case (state)
      IDLE:    cmd = accept ? TX_LOAD : TX_CLR;
      SEND:    cmd = (cnt == SEND_LAST) ? TX_CLR : TX_SHIFT;
      GAP:     cmd = accept ? TX_LOAD : (gap_last ? TX_CLR : TX_GAP);
      default: cmd = TX_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (ena) begin
      frame_start <= accept;
      unique case (state)
        IDLE: if (accept) begin
          state <= SEND;
          busy  <= 1'b1;
        end
        SEND: if (cnt == SEND_LAST) state <= GAP;
        GAP: begin
          if (accept) begin
            state <= SEND;
          end else if (gap_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  hamming74_shift_tx #(.IDLE_LEVEL(IDLE_LEVEL)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .cmd     (cmd),
    .word    (word),
    .bit_out (encode_out),
    .cnt     (cnt)
  );

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Randomized self-checking bench for the Hamming(7,4) serial encoder.
module tb_hamming74_serial_encoder;

  logic       clk, rst, ena, data_valid, data_ready, err_inject;
  logic [3:0] data_in;
  logic [2:0] err_pos;
  logic       encode_out, frame_start, busy;

  int passed = 0;
  int total  = 0;

  logic [63:0] eo, fs, bz, rd;

  hamming74_serial_encoder #(.GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .err_inject  (err_inject),
    .err_pos     (err_pos),
    .encode_out  (encode_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Codeword straight from the parity equations, with optional bit flip.
  function automatic logic [6:0] ref_code(input logic [3:0] d, input logic inj, input logic [2:0] p);
    logic [6:0] c;
    c[0] = d[0];
    c[1] = d[1];
    c[2] = d[2];
    c[4] = d[3];
    c[3] = d[2] ^ d[1] ^ d[0];
    c[5] = d[3] ^ d[1] ^ d[0];
    c[6] = d[3] ^ d[2] ^ d[0];
    if (inj && p != 3'd7) c[p] = ~c[p];
    return c;
  endfunction

  // Nearest-codeword decode by exhaustive search.
  function automatic logic [3:0] ref_decode(input logic [6:0] r);
    for (int v = 0; v < 16; v++)
      if ($countones(ref_code(4'(v), 1'b0, 3'd7) ^ r) <= 1) return 4'(v);
    return 4'hx;
  endfunction

  function automatic logic [2:0] checks(input logic [6:0] r);
    return {r[6] ^ r[4] ^ r[2] ^ r[0], r[5] ^ r[4] ^ r[1] ^ r[0], r[3] ^ r[2] ^ r[1] ^ r[0]};
  endfunction

  task automatic start(input logic [3:0] d, input logic inj, input logic [2:0] p);
    @(negedge clk);
    data_in = d; err_inject = inj; err_pos = p; data_valid = 1'b1;
  endtask

  // Records n cycles of outputs; index 0 is the cycle after the first accept.
  task automatic capture(input int n, input int drop_at, input logic [3:0] nd);
    eo = '0; fs = '0; bz = '0; rd = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eo[i] = encode_out; fs[i] = frame_start; bz[i] = busy; rd[i] = data_ready;
      if (i == 0) begin data_in = nd; err_inject = 1'b0; err_pos = 3'($urandom); end
      if (i == drop_at) data_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; data_valid = 1'b0; data_in = '0; err_inject = 1'b0; err_pos = 3'd7;
    repeat (2) @(negedge clk);
    total++; if (data_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%b exp=0", data_ready); else passed++;
    total++; if (encode_out !== 1'b0) $display("FAIL reset_eo got=%b exp=0", encode_out); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b exp=0", frame_start); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (data_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", data_ready); else passed++;
  endtask

  task automatic test_vectors;
    logic [3:0] vec [4];
    logic [3:0] d;
    logic       inj;
    logic [2:0] p;
    logic [6:0] exp_c, rx;
    vec = '{4'b1011, 4'b0001, 4'b1111, 4'b0000};
    for (int n = 0; n < 12; n++) begin
      d   = (n < 4) ? vec[n] : 4'($urandom);
      inj = (n < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      p   = 3'($urandom_range(0, 7));
      exp_c = ref_code(d, inj, p);
      start(d, inj, p);
      total++; if (data_ready !== 1'b1) $display("FAIL vec%0d_ready_idle got=%b exp=1", n, data_ready); else passed++;
      capture(9, 0, 4'h0);
      rx = eo[6:0];
      total++; if (rx !== exp_c) $display("FAIL vec%0d_bits d=%h got=%b exp=%b", n, d, rx, exp_c); else passed++;
      if (n == 0) begin
        total++; if (rx !== 7'b0110011) $display("FAIL vec_1011_literal got=%b exp=0110011", rx); else passed++;
      end
      if (n == 1) begin
        total++; if (rx !== 7'b1101001) $display("FAIL vec_0001_literal got=%b exp=1101001", rx); else passed++;
      end
      total++; if (fs[6:0] !== 7'b0000001) $display("FAIL vec%0d_fs got=%b exp=0000001", n, fs[6:0]); else passed++;
      total++; if (bz[8:0] !== 9'h0FF) $display("FAIL vec%0d_busy got=%b exp=011111111", n, bz[8:0]); else passed++;
      total++; if (rd[8:0] !== 9'h180) $display("FAIL vec%0d_ready got=%b exp=110000000", n, rd[8:0]); else passed++;
      total++; if (eo[8:7] !== 2'b00) $display("FAIL vec%0d_gap_idle got=%b exp=00", n, eo[8:7]); else passed++;
      if (!(inj && p != 3'd7)) begin
        total++; if (checks(rx) !== 3'b000) $display("FAIL vec%0d_checks got=%b exp=000", n, checks(rx)); else passed++;
      end
      total++; if (ref_decode(rx) !== d) $display("FAIL vec%0d_decode got=%h exp=%h", n, ref_decode(rx), d); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    start(4'b1011, 1'b0, 3'd7);
    capture(17, 8, 4'b0001);
    total++; if (eo[6:0] !== ref_code(4'b1011, 1'b0, 3'd7)) $display("FAIL b2b_frame1 got=%b exp=%b", eo[6:0], ref_code(4'b1011, 1'b0, 3'd7)); else passed++;
    total++; if (eo[14:8] !== ref_code(4'b0001, 1'b0, 3'd7)) $display("FAIL b2b_frame2 got=%b exp=%b", eo[14:8], ref_code(4'b0001, 1'b0, 3'd7)); else passed++;
    total++; if ({eo[16:15], eo[7]} !== 3'b000) $display("FAIL b2b_gaps got=%b exp=000", {eo[16:15], eo[7]}); else passed++;
    total++; if (fs[16:0] !== 17'h00101) $display("FAIL b2b_fs got=%b exp=%b", fs[16:0], 17'h00101); else passed++;
    total++; if (bz[16:0] !== 17'h0FFFF) $display("FAIL b2b_busy got=%b exp=%b", bz[16:0], 17'h0FFFF); else passed++;
    total++; if (rd[16:0] !== 17'h18080) $display("FAIL b2b_ready got=%b exp=%b", rd[16:0], 17'h18080); else passed++;
  endtask

  task automatic test_inject;
    logic [2:0] pos;
    start(4'b1011, 1'b1, 3'd4);
    capture(9, 0, 4'h0);
    total++; if (eo[6:0] !== 7'b0100011) $display("FAIL inj_pos4_bits got=%b exp=0100011", eo[6:0]); else passed++;
    total++; if (checks(eo[6:0]) === 3'b000) $display("FAIL inj_pos4_checks got=%b exp=nonzero", checks(eo[6:0])); else passed++;
    total++; if (ref_decode(eo[6:0]) !== 4'b1011) $display("FAIL inj_pos4_decode got=%h exp=b", ref_decode(eo[6:0])); else passed++;
    start(4'b1011, 1'b1, 3'd7);
    capture(9, 0, 4'h0);
    total++; if (eo[6:0] !== 7'b0110011) $display("FAIL inj_pos7_bits got=%b exp=0110011", eo[6:0]); else passed++;
    pos = 3'($urandom_range(0, 6));
    start(4'b0110, 1'b1, pos);
    capture(9, 0, 4'h0);
    total++; if ($countones(eo[6:0] ^ ref_code(4'b0110, 1'b0, 3'd7)) != 1) $display("FAIL inj_rand_pos%0d got=%b exp=%b", pos, eo[6:0], ref_code(4'b0110, 1'b1, pos)); else passed++;
    total++; if (eo[6:0] !== ref_code(4'b0110, 1'b1, pos)) $display("FAIL inj_rand_bits got=%b exp=%b", eo[6:0], ref_code(4'b0110, 1'b1, pos)); else passed++;
  endtask

  task automatic test_ena_stall;
    logic [6:0] exp_c;
    exp_c = ref_code(4'b1011, 1'b0, 3'd7);
    @(negedge clk);
    ena = 1'b0; data_valid = 1'b1; data_in = 4'b1011; err_inject = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++; if (data_ready !== 1'b0) $display("FAIL ena_idle_ready got=%b exp=0", data_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL ena_idle_busy got=%b exp=0", busy); else passed++;
    end
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      total++; if (encode_out !== exp_c[i]) $display("FAIL ena_pre_bit%0d got=%b exp=%b", i, encode_out, exp_c[i]); else passed++;
    end
    ena = 1'b0; data_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++; if (encode_out !== exp_c[3]) $display("FAIL ena_hold%0d got=%b exp=%b", j, encode_out, exp_c[3]); else passed++;
      total++; if (data_ready !== 1'b0) $display("FAIL ena_hold_ready%0d got=%b exp=0", j, data_ready); else passed++;
      total++; if ({busy, frame_start} !== 2'b10) $display("FAIL ena_hold_flags%0d got=%b exp=10", j, {busy, frame_start}); else passed++;
    end
    ena = 1'b1; data_valid = 1'b0;
    for (int i = 4; i < 7; i++) begin
      @(negedge clk);
      total++; if (encode_out !== exp_c[i]) $display("FAIL ena_post_bit%0d got=%b exp=%b", i, encode_out, exp_c[i]); else passed++;
    end
    @(negedge clk);
    total++; if ({encode_out, data_ready, busy} !== 3'b011) $display("FAIL ena_gap got=%b exp=011", {encode_out, data_ready, busy}); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL ena_end_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [3:0] d;
    logic [6:0] exp_c;
    d = 4'($urandom);
    exp_c = ref_code(d, 1'b0, 3'd7);
    start(d, 1'b0, 3'd7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      total++; if (encode_out !== exp_c[i]) $display("FAIL rstmid_bit%0d got=%b exp=%b", i, encode_out, exp_c[i]); else passed++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({encode_out, busy, frame_start, data_ready} !== 4'b0000) $display("FAIL rstmid_abort got=%b exp=0000", {encode_out, busy, frame_start, data_ready}); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({data_ready, busy, encode_out} !== 3'b100) $display("FAIL rstmid_idle got=%b exp=100", {data_ready, busy, encode_out}); else passed++;
    start(4'b0001, 1'b0, 3'd7);
    capture(9, 0, 4'h0);
    total++; if (eo[6:0] !== 7'b1101001) $display("FAIL rstmid_fresh_bits got=%b exp=1101001", eo[6:0]); else passed++;
    total++; if (fs[6:0] !== 7'b0000001) $display("FAIL rstmid_fresh_fs got=%b exp=0000001", fs[6:0]); else passed++;
    total++; if (bz[8:0] !== 9'h0FF) $display("FAIL rstmid_fresh_busy got=%b exp=011111111", bz[8:0]); else passed++;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_inject;
    test_ena_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hamming74_serial_encoder.md
Name: hamming74_serial_encoder

Overview:
Transmit-side partner of the Hamming(7,4) serial decoder. Accepts a 4-bit nibble through a valid/ready handshake, computes the 7-bit codeword and shifts it out one bit per enabled clock, LSB first. Each frame is 7 code bits followed by GAP_CYCLES idle bits, so a downstream decoder with an 8-count frame counter stays aligned. Optional single-bit error injection lets the bench exercise decoder correction.

Parameters:
GAP_CYCLES, 1, idle cycles driven as 0 after code bit 6 (1..7); the default gives an 8-cycle frame.
IDLE_LEVEL, 0, value driven on encode_out when no bit is being sent.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ena  in  1  clock enable; when low all state, including outputs, holds
data_in  in  4  nibble d[3:0] to encode
data_valid  in  1  data_in is valid
data_ready  out  1  encoder can accept a nibble this cycle
err_inject  in  1  sampled with the handshake; flip one code bit of this frame
err_pos  in  3  codeword index (0..6) to flip; value 7 means no flip
encode_out  out  1  serial code bit
frame_start  out  1  high while code bit 0 is on encode_out
busy  out  1  high from code bit 0 through the last gap cycle

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, shift register 0, bit counter 0, encode_out=IDLE_LEVEL, frame_start=0, busy=0, data_ready=0 in the reset cycle and 1 afterwards. Reset mid-frame aborts the frame; no partial bits resume.
- Codeword c[6:0]:
  - c0=d0, c1=d1, c2=d2, c4=d3.
  - c3=d2^d1^d0, c5=d3^d1^d0, c6=d3^d2^d0.
  - All three decoder checks (c6^c4^c2^c0, c5^c4^c1^c0, c3^c2^c1^c0) are then 0.
- Injection: if err_inject=1 and err_pos<7 at acceptance, the latched codeword has c[err_pos] inverted. err_pos=7 leaves it unchanged.
- Handshake:
  - Accept when ena & data_valid & data_ready at a rising edge.
  - data_in, err_inject and err_pos are sampled only at that edge.
  - data_valid without ready is ignored; no buffering.
- FSM states: IDLE, SEND, GAP.
  - IDLE: data_ready=1, encode_out=IDLE_LEVEL. On accept, latch the codeword and go to SEND with count=0.
  - SEND: encode_out=c[count] (registered). count increments each enabled cycle. After count=6, go to GAP (count=0).
  - GAP: encode_out=IDLE_LEVEL for GAP_CYCLES enabled cycles. data_ready=1 on the last gap cycle only. An accept there goes directly to SEND (back-to-back frames, period 7+GAP_CYCLES). Otherwise go to IDLE.
  - data_ready=0 throughout SEND and the non-final GAP cycles.
- Latency: bit c0 appears on encode_out in the cycle after the accepting edge, with frame_start=1 in that same cycle. Bit k appears k cycles later (counted in enabled cycles).
- ena=0: FSM, counters and outputs frozen. data_ready is forced to 0 so no accept can occur.
- busy=1 in SEND and GAP, 0 in IDLE.
- No combinational path from inputs to outputs; all outputs are registered except data_ready, which is decoded from state.

Decomposition:
- Shared package hamming74_pkg holds:
  - constants CODE_W=7, DATA_W=4, and the data-bit positions {0,1,2,4} and parity positions {3,5,6};
  - function hamming74_encode(d) returning c[6:0];
  - function hamming74_syndrome(c), reused by the decoder.
- FSM state typedef (IDLE/SEND/GAP) lives locally.
- One natural sub-module: hamming74_shift_tx, a 7-bit load/shift register with a bit counter. The top level holds the FSM and handshake.

Test Plan:
- Reset then accept data_in=4'b1011, no inject -> encode_out over 7 cycles = 1,1,0,0,1,1,0, then one 0. frame_start only on the first bit. data_ready high again on the gap cycle.
- data_in=4'b0001 -> serial 1,0,0,1,0,1,1. data_in=4'b1111 -> seven 1s. data_in=4'b0000 -> seven 0s. Every received word has all three checks equal to 0.
- Back-to-back: data_valid held high with 4'b1011 then 4'b0001 -> frames exactly 8 cycles apart with no extra gap. busy stays 1 across the boundary.
- Inject: 4'b1011 with err_inject=1, err_pos=4 -> bit 4 sent as 0 (1,1,0,0,0,1,0). Chained into the decoder, output is 4'b1011.
- ena toggled low for 3 cycles during SEND bit 3 -> encode_out holds bit 3 for those cycles, then resumes with bit 4. data_ready stays 0. Total bit count is 7.
- rst=1 during SEND bit 5 -> next cycle encode_out=0, busy=0, frame_start=0. A fresh 4'b0001 frame then transmits correctly from c0.
